scoreboard_counter: RTL and testbench
=====================================

Name: scoreboard_counter

Overview:
Multi-channel, single-clock up/down score counter for the scoreboard display path. It replaces the dual-clock counter, which used separate up/down clocks, with a single system clock. Each channel takes raw up/down button levels, synchronises and rising-edge-detects them, and steps a bounded counter. The counter either saturates or wraps at its limits. Outputs feed the 7-segment/BCD display stage directly.

Parameters:
NUM_CH, 2, number of independent score channels (teams); >= 1
BW, 7, counter width per channel in bits
MAX_VAL, 99, upper count limit; must satisfy MAX_VAL < 2**BW
WRAP, 0, 0 = saturate at 0/MAX_VAL; 1 = wrap MAX_VAL->0 on up and 0->MAX_VAL on down

Ports:
clk_i  input  1  system clock; all state on rising edge
rst_i  input  1  asynchronous, active-high reset
up_i  input  NUM_CH  raw count-up levels, one per channel, asynchronous to clk_i
down_i  input  NUM_CH  raw count-down levels, one per channel, asynchronous to clk_i
clear_i  input  1  synchronous clear of all channels; already synchronous to clk_i
counter_val_o  output  NUM_CH*BW  packed counts; channel n occupies bits [n*BW +: BW]
at_max_o  output  NUM_CH  high while channel count == MAX_VAL
at_min_o  output  NUM_CH  high while channel count == 0
event_o  output  NUM_CH  one-cycle pulse in the cycle after a channel's count changed

Behaviour:
- Reset (rst_i high, asynchronous):
  - all counts = 0; all synchroniser and edge-history flops = 0; event_o = 0
  - at_min_o = all 1; at_max_o = all 0
  - outputs hold these values for as long as rst_i is high
- Input path, per channel and per direction:
  - 2-flop synchroniser (s1, s2) plus a history flop p
  - step pulse = s2 & ~p
  - A level first sampled high at edge k produces its pulse during cycle k+1..k+2. The count updates at edge k+2.
  - A held level yields exactly one step; no auto-repeat.
  - Pulses shorter than one clock period may be missed; this is accepted, and debounce is handled upstream.
- Per-channel update at each edge, in priority order:
  1. clear_i = 1 -> count <= 0. Any pending pulses that cycle are discarded. Edge-history flops still update.
  2. up pulse & down pulse together -> no change.
  3. up pulse only:
     - count < MAX_VAL -> count + 1
     - count == MAX_VAL -> stays MAX_VAL (WRAP=0) or becomes 0 (WRAP=1)
  4. down pulse only:
     - count > 0 -> count - 1
     - count == 0 -> stays 0 (WRAP=0) or becomes MAX_VAL (WRAP=1)
  5. no pulse -> hold.
- Channels are fully independent. Simultaneous events on different channels are all applied in the same cycle.
- Arithmetic is BW-bit unsigned. The count never leaves [0, MAX_VAL].
- Flags:
  - at_max_o and at_min_o are combinational decodes of the registered count.
  - With MAX_VAL = 0 both flags are permanently 1.
- event_o:
  - registered; high for one cycle after any edge where the channel's count value actually changed (step, wrap or clear)
  - saturated steps and clear of an already-zero channel do not pulse
- Reset mid-operation:
  - asynchronous clear of everything, including any in-flight synchroniser state
  - a button held through reset release is seen as a new rising edge and produces one step, 3 edges after release
- Latency from a raw input rise to counter_val_o change: 2 to 3 clock edges, depending on phase. Bench checks use "within 3 edges".

Test Plan:
- Reset then idle: rst_i pulse mid-cycle -> counter_val_o = 0 immediately (asynchronous); at_min_o = all 1, at_max_o = 0, event_o = 0.
- Up counting, channel 0: 5 up_i[0] presses (each 4 clk high, 4 low) -> ch0 = 5, ch1 = 0; event_o[0] pulses exactly 5 times, each 1 cycle; 1 hold of 20 clk -> count advances by only 1.
- Saturation (WRAP=0): 105 up presses -> ch0 = 99 with at_max_o[0] = 1; further up -> stays 99, no event_o. 100 down presses -> ch0 = 0 with at_min_o[0] = 1; further down -> stays 0.
- Wrap (WRAP=1, MAX_VAL=9): from 9, 1 up -> 0; from 0, 1 down -> 9; event_o pulses on each.
- Simultaneous/priority: up_i[0] and down_i[0] rise in the same cycle -> ch0 unchanged, no event. up_i[1] and clear_i in the same cycle with ch1 = 7 -> ch1 = 0, single event_o[1].
- Reset with held button: up_i[0] held high across rst_i deassert -> ch0 = 1 within 3 edges of release, then stable while held.

Source files
------------

// File: rtl/scoreboard_counter.sv
// Multi-channel single-clock up/down score counter. Each channel synchronises raw
// button levels, detects rising edges and steps a bounded saturating or wrapping count.
module scoreboard_counter #(
  parameter int NUM_CH  = 2,
  parameter int BW      = 7,
  parameter int MAX_VAL = 99,
  parameter bit WRAP    = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CH-1:0]    up_i,
  input  logic [NUM_CH-1:0]    down_i,
  input  logic                 clear_i,
  output logic [NUM_CH*BW-1:0] counter_val_o,
  output logic [NUM_CH-1:0]    at_max_o,
  output logic [NUM_CH-1:0]    at_min_o,
  output logic [NUM_CH-1:0]    event_o
);

  localparam logic [BW-1:0] MAX_C  = BW'(MAX_VAL);
  localparam logic [BW-1:0] ZERO_C = '0;
  localparam logic [BW-1:0] ONE_C  = BW'(1);

  // Synchroniser stages (s1, s2) and edge history (p) for both directions.
  logic [NUM_CH-1:0] up_s1_q, up_s2_q, up_p_q;
  logic [NUM_CH-1:0] dn_s1_q, dn_s2_q, dn_p_q;
  logic [NUM_CH-1:0] up_pulse, dn_pulse;

  logic [NUM_CH*BW-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]    event_q, event_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      up_s1_q <= '0;
      up_s2_q <= '0;
      up_p_q  <= '0;
      dn_s1_q <= '0;
      dn_s2_q <= '0;
      dn_p_q  <= '0;
    end else begin
      up_s1_q <= up_i;
      up_s2_q <= up_s1_q;
      up_p_q  <= up_s2_q;
      dn_s1_q <= down_i;
      dn_s2_q <= dn_s1_q;
      dn_p_q  <= dn_s2_q;
    end
  end

  assign up_pulse = up_s2_q & ~up_p_q;
  assign dn_pulse = dn_s2_q & ~dn_p_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [BW-1:0] cur;
    logic [BW-1:0] nxt;

    assign cur = cnt_q[g*BW +: BW];

    // Clear wins over any pulse; simultaneous up and down cancel out.
    always_comb begin
      nxt = cur;
      if (clear_i) begin
        nxt = ZERO_C;
      end else if (up_pulse[g] && !dn_pulse[g]) begin
        if (cur < MAX_C) begin
          nxt = cur + ONE_C;
        end else if (WRAP) begin
          nxt = ZERO_C;
        end else begin
          nxt = MAX_C;
        end
      end else if (dn_pulse[g] && !up_pulse[g]) begin
        if (cur > ZERO_C) begin
          nxt = cur - ONE_C;
        end else if (WRAP) begin
          nxt = MAX_C;
        end else begin
          nxt = ZERO_C;
        end
      end
    end

    assign cnt_d[g*BW +: BW] = nxt;
    assign event_d[g]        = (nxt != cur);
    assign at_max_o[g]       = (cur == MAX_C);
    assign at_min_o[g]       = (cur == ZERO_C);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      event_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      event_q <= event_d;
    end
  end

  assign counter_val_o = cnt_q;
  assign event_o       = event_q;

endmodule

// File: tb/tb_scoreboard_counter.sv
// Bench for scoreboard_counter: a saturating instance (defaults) and a wrapping
// instance (MAX_VAL=9), checked every cycle against a rise-to-step model.
module tb_scoreboard_counter;

  localparam int MAX_S = 99;
  localparam int MAX_W = 9;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       clear = 1'b0;
  logic [1:0] up_s  = '0, dn_s = '0, up_w = '0, dn_w = '0;

  logic [13:0] val_s;
  logic [7:0]  val_w;
  logic [1:0]  amax_s, amin_s, ev_s, amax_w, amin_w, ev_w;

  always #5 clk = ~clk;

  scoreboard_counter #(.NUM_CH(2), .BW(7), .MAX_VAL(MAX_S), .WRAP(1'b0)) dut_sat (
    .clk_i(clk), .rst_i(rst), .up_i(up_s), .down_i(dn_s), .clear_i(clear),
    .counter_val_o(val_s), .at_max_o(amax_s), .at_min_o(amin_s), .event_o(ev_s)
  );

  scoreboard_counter #(.NUM_CH(2), .BW(4), .MAX_VAL(MAX_W), .WRAP(1'b1)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .up_i(up_w), .down_i(dn_w), .clear_i(clear),
    .counter_val_o(val_w), .at_max_o(amax_w), .at_min_o(amin_w), .event_o(ev_w)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a rise of the sampled level at edge k steps the count at edge k+2.
  int m_cnt [2][2];
  bit m_ev  [2][2];
  bit m_pu  [2][2], m_pd  [2][2];
  bit m_ru1 [2][2], m_ru2 [2][2], m_rd1 [2][2], m_rd2 [2][2];
  logic [19:0] exp_s_q[$];
  logic [19:0] exp_w_q[$];

  function automatic int next_count(int c, bit u, bit d, int mx, bit w);
    if (u && !d) return (c < mx) ? c + 1 : (w ? 0 : mx);
    if (d && !u) return (c > 0) ? c - 1 : (w ? mx : 0);
    return c;
  endfunction

  function automatic logic [19:0] pack_exp(int d);
    int mx, base;
    logic [19:0] e;
    mx   = (d == 0) ? MAX_S : MAX_W;
    base = (d == 0) ? 128 : 16;
    e[19:6] = 14'(m_cnt[d][1] * base + m_cnt[d][0]);
    e[5:4]  = {m_cnt[d][1] == mx, m_cnt[d][0] == mx};
    e[3:2]  = {m_cnt[d][1] == 0, m_cnt[d][0] == 0};
    e[1:0]  = {m_ev[d][1], m_ev[d][0]};
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        bit su, sd, stu, std;
        int nx;
        if (rst) begin
          m_cnt[d][c] = 0; m_ev[d][c] = 0; m_pu[d][c] = 0; m_pd[d][c] = 0;
          m_ru1[d][c] = 0; m_ru2[d][c] = 0; m_rd1[d][c] = 0; m_rd2[d][c] = 0;
        end else begin
          su  = (d == 0) ? up_s[c] : up_w[c];
          sd  = (d == 0) ? dn_s[c] : dn_w[c];
          stu = m_ru2[d][c];
          std = m_rd2[d][c];
          m_ru2[d][c] = m_ru1[d][c];
          m_ru1[d][c] = su & ~m_pu[d][c];
          m_rd2[d][c] = m_rd1[d][c];
          m_rd1[d][c] = sd & ~m_pd[d][c];
          m_pu[d][c]  = su;
          m_pd[d][c]  = sd;
          nx = clear ? 0 : next_count(m_cnt[d][c], stu, std,
                                      (d == 0) ? MAX_S : MAX_W, d == 1);
          m_ev[d][c]  = (nx != m_cnt[d][c]);
          m_cnt[d][c] = nx;
        end
      end
    end
    exp_s_q.push_back(pack_exp(0));
    exp_w_q.push_back(pack_exp(1));
  end

  // Compare process: the newest model entry describes the outputs at this negedge.
  task automatic compare_one(input int d);
    logic [19:0] e, a;
    if (d == 0) begin
      if (exp_s_q.size() == 0) return;
      while (exp_s_q.size() > 1) void'(exp_s_q.pop_front());
      e = exp_s_q.pop_front();
      a = {val_s, amax_s, amin_s, ev_s};
    end else begin
      if (exp_w_q.size() == 0) return;
      while (exp_w_q.size() > 1) void'(exp_w_q.pop_front());
      e = exp_w_q.pop_front();
      a = {6'b0, val_w, amax_w, amin_w, ev_w};
    end
    check((d == 0) ? "sat counter_val"  : "wrap counter_val", 32'(a[19:6]), 32'(e[19:6]));
    check((d == 0) ? "sat at_max"       : "wrap at_max",      32'(a[5:4]),  32'(e[5:4]));
    check((d == 0) ? "sat at_min"       : "wrap at_min",      32'(a[3:2]),  32'(e[3:2]));
    check((d == 0) ? "sat event"        : "wrap event",       32'(a[1:0]),  32'(e[1:0]));
  endtask

  int ev_cnt [2][2];

  always @(negedge clk) begin
    compare_one(0);
    compare_one(1);
    for (int c = 0; c < 2; c++) begin
      if (ev_s[c] === 1'b1) ev_cnt[0][c]++;
      if (ev_w[c] === 1'b1) ev_cnt[1][c]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int d, input int c, input bit dn, input bit v);
    if (d == 0 && !dn) up_s[c] = v;
    else if (d == 0)   dn_s[c] = v;
    else if (!dn)      up_w[c] = v;
    else               dn_w[c] = v;
  endtask

  task automatic press(input int d, input int c, input bit dn, input int hi, input int lo);
    set_btn(d, c, dn, 1'b1);
    tick(hi);
    set_btn(d, c, dn, 1'b0);
    tick(lo);
  endtask

  task automatic clr_ev();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) ev_cnt[d][c] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  edges;
    bit  found;
    tick(3);
    #2 rst = 1'b0;
    tick(2);
    check("idle val", 32'(val_s), 0);
    check("idle at_min", 32'(amin_s), 3);
    check("idle at_max", 32'(amax_s), 0);
    check("idle event", 32'(ev_s), 0);

    clr_ev();
    repeat (5) press(0, 0, 1'b0, 4, 4);
    tick(2);
    check("up5 ch0", 32'(val_s[6:0]), 5);
    check("up5 ch1", 32'(val_s[13:7]), 0);
    check("up5 events", 32'(ev_cnt[0][0]), 5);
    clr_ev();
    press(0, 0, 1'b0, 20, 4);
    tick(2);
    check("hold ch0", 32'(val_s[6:0]), 6);
    check("hold events", 32'(ev_cnt[0][0]), 1);

    #2 rst = 1'b1;
    #1;
    check("async rst val", 32'(val_s), 0);
    check("async rst at_min", 32'(amin_s), 3);
    check("async rst event", 32'(ev_s), 0);
    tick(2);
    #2 rst = 1'b0;
    tick(2);

    repeat (105) press(0, 0, 1'b0, 4, 4);
    tick(2);
    check("sat up ch0", 32'(val_s[6:0]), 99);
    check("sat at_max", 32'(amax_s[0]), 1);
    clr_ev();
    repeat (3) press(0, 0, 1'b0, 4, 4);
    check("sat hold ch0", 32'(val_s[6:0]), 99);
    check("sat no event", 32'(ev_cnt[0][0]), 0);
    repeat (100) press(0, 0, 1'b1, 4, 4);
    tick(2);
    check("sat down ch0", 32'(val_s[6:0]), 0);
    check("sat at_min", 32'(amin_s[0]), 1);
    clr_ev();
    repeat (3) press(0, 0, 1'b1, 4, 4);
    check("floor ch0", 32'(val_s[6:0]), 0);
    check("floor no event", 32'(ev_cnt[0][0]), 0);

    repeat (9) press(1, 0, 1'b0, 4, 4);
    check("wrap reach 9", 32'(val_w[3:0]), 9);
    check("wrap at_max", 32'(amax_w[0]), 1);
    clr_ev();
    press(1, 0, 1'b0, 4, 4);
    check("wrap 9->0", 32'(val_w[3:0]), 0);
    check("wrap up event", 32'(ev_cnt[1][0]), 1);
    clr_ev();
    press(1, 0, 1'b1, 4, 4);
    check("wrap 0->9", 32'(val_w[3:0]), 9);
    check("wrap down event", 32'(ev_cnt[1][0]), 1);

    repeat (3) press(0, 0, 1'b0, 4, 4);
    clr_ev();
    set_btn(0, 0, 1'b0, 1'b1);
    set_btn(0, 0, 1'b1, 1'b1);
    tick(4);
    set_btn(0, 0, 1'b0, 1'b0);
    set_btn(0, 0, 1'b1, 1'b0);
    tick(4);
    check("up+down ch0", 32'(val_s[6:0]), 3);
    check("up+down no event", 32'(ev_cnt[0][0]), 0);

    repeat (7) press(0, 1, 1'b0, 4, 4);
    check("ch1 reach 7", 32'(val_s[13:7]), 7);
    clr_ev();
    set_btn(0, 1, 1'b0, 1'b1);
    tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear vs up ch1", 32'(val_s[13:7]), 0);
    tick(3);
    set_btn(0, 1, 1'b0, 1'b0);
    tick(4);
    check("clear ch1 stays", 32'(val_s[13:7]), 0);
    check("clear single event", 32'(ev_cnt[0][1]), 1);

    set_btn(0, 0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    tick(3);
    #2 rst = 1'b0;
    edges = 0;
    found = 1'b0;
    for (int i = 1; i <= 3 && !found; i++) begin
      @(posedge clk);
      #1;
      if (val_s[6:0] == 7'd1) begin
        found = 1'b1;
        edges = i;
      end
    end
    check("held rst step within 3", 32'(found), 1);
    check("held rst edge count", 32'(edges), 3);
    tick(10);
    check("held rst stable", 32'(val_s[6:0]), 1);
    set_btn(0, 0, 1'b0, 1'b0);
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
